dmem_pipe: RTL and testbench



---
 rtl/dmem_pkg.sv | 57 +++++
 rtl/dmem_pipe_if.sv | 24 ++
 rtl/dmem_ram.sv | 26 ++
 rtl/dmem_pipe.sv | 119 +++++++++++
 tb/tb_dmem_pipe.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined RV32 data memory.
// Size encodings follow RV funct3; stage records carry one request down the read pipe.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic        err;
    logic [2:0]  size;
    logic [1:0]  lane;
    logic [31:0] data;
  } stage_t;

  // Size legality and natural alignment only; range is checked by the caller.
  function automatic logic legal_access(logic we, logic [2:0] size, logic [1:0] addr);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_BU:   ok = !we;
      SZ_H:    ok = !addr[0];
      SZ_HU:   ok = !we && !addr[0];
      SZ_W:    ok = (addr == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] ld_extend(logic [2:0] size, logic [1:0] lane,
                                            logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = {{24{b[7]}}, b};
      SZ_BU:   r = {24'd0, b};
      SZ_H:    r = {{16{h[15]}}, h};
      SZ_HU:   r = {16'd0, h};
      SZ_W:    r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_pipe_if.sv
// Request/response handshake bundle between the MEM stage and the data memory.
interface dmem_pipe_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_is_store;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_store
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_store
  );
endinterface

// File: rtl/dmem_ram.sv
// Word-wide RAM with byte-enable write and combinational read.
// Kept separate so it can be replaced by an SRAM macro wrapper.
module dmem_ram #(
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined RV32 data memory: RD_LAT-deep read pipe, whole-pipe stall on response back-pressure.
// Optional DMEM_PERF_CNT_EN adds load/store/error counters counted at request accept.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_pipe_if.slave  bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] perf_ld_cnt,
  output logic [31:0] perf_st_cnt,
  output logic [31:0] perf_err_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  stage_t          stage_q [RD_LAT];
  stage_t          stage_in;
  stage_t          last;
  logic            stall;
  logic            accept;
  logic            in_range;
  logic            req_err;
  logic            ram_we;
  logic [3:0]      be;
  logic [31:0]     wdata_lane;
  logic [31:0]     ram_rdata;
  logic [AW-1:0]   widx;

  assign last          = stage_q[RD_LAT-1];
  assign stall         = last.valid && !bus.rsp_ready;
  assign bus.req_ready = !stall;
  assign accept        = bus.req_valid && !stall && rst;

  assign widx     = bus.req_addr[AW+1:2];
  assign in_range = (bus.req_addr >> (AW + 2)) == 32'd0;
  assign req_err  = !in_range || !legal_access(bus.req_we, bus.req_size, bus.req_addr[1:0]);
  assign ram_we   = accept && bus.req_we && !req_err;

  // Store data arrives low-aligned; replicate it so every enabled lane sees its byte.
  always_comb begin
    be         = 4'b0000;
    wdata_lane = bus.req_wdata;
    case (bus.req_size)
      SZ_B: begin
        be         = 4'b0001 << bus.req_addr[1:0];
        wdata_lane = {4{bus.req_wdata[7:0]}};
      end
      SZ_H: begin
        be         = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{bus.req_wdata[15:0]}};
      end
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  dmem_ram #(
    .AW (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .be_i    (be),
    .addr_i  (widx),
    .wdata_i (wdata_lane),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    stage_in       = '0;
    stage_in.valid = accept;
    stage_in.we    = bus.req_we;
    stage_in.err   = req_err;
    stage_in.size  = bus.req_size;
    stage_in.lane  = bus.req_addr[1:0];
    stage_in.data  = (req_err || bus.req_we) ? 32'd0 : ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) stage_q[i] <= '0;
    end else if (!stall) begin
      stage_q[0] <= stage_in;
      for (int i = 1; i < int'(RD_LAT); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign bus.rsp_valid    = last.valid;
  assign bus.rsp_err      = last.valid && last.err;
  assign bus.rsp_is_store = last.valid && last.we;
  assign bus.rsp_rdata    = (last.valid && !last.err && !last.we) ?
                            ld_extend(last.size, last.lane, last.data) : 32'd0;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] ld_cnt_q, st_cnt_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_cnt_q  <= '0;
      st_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (accept) begin
      if (req_err)         err_cnt_q <= err_cnt_q + 32'd1;
      else if (bus.req_we) st_cnt_q  <= st_cnt_q + 32'd1;
      else                 ld_cnt_q  <= ld_cnt_q + 32'd1;
    end
  end

  assign perf_ld_cnt  = ld_cnt_q;
  assign perf_st_cnt  = st_cnt_q;
  assign perf_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_pipe.sv
// Scoreboard bench for dmem_pipe: byte-array reference model, random traffic and back-pressure.
module tb_dmem_pipe;

  localparam int unsigned DEPTH_WORDS = 1024;
  localparam int unsigned RD_LAT      = 3;
  localparam int unsigned WIN_WORDS   = 64;
  localparam int unsigned MEM_BYTES   = 4 * DEPTH_WORDS;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        st;
    int          acc;
    bit          timed;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  dmem_pipe_if bus ();
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] perf_ld, perf_st, perf_err;
`endif

  dmem_pipe #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .RD_LAT      (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DMEM_PERF_CNT_EN
    ,
    .perf_ld_cnt  (perf_ld),
    .perf_st_cnt  (perf_st),
    .perf_err_cnt (perf_err)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem_m [MEM_BYTES];
  exp_t       exp_q [$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         rr_mode = 0;
  int         n_ld = 0, n_st = 0, n_err = 0;
  bit         timed_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, bus.rsp_err}, 32'd0);
    check({tag, "_rsp_is_store"}, {31'd0, bus.rsp_is_store}, 32'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
  endtask

  task automatic check_perf(input string tag);
`ifdef DMEM_PERF_CNT_EN
    check({tag, "_perf_ld"}, perf_ld, n_ld);
    check({tag, "_perf_st"}, perf_st, n_st);
    check({tag, "_perf_err"}, perf_err, n_err);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Little-endian byte memory; accesses applied in accept order.
  function automatic exp_t model_req(bit we, logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
    exp_t        e;
    int          nb;
    logic [31:0] v;
    e.rdata = '0; e.err = 1'b0; e.st = we; e.acc = 0; e.timed = 1'b0;
    case (sz)
      3'b000, 3'b100: nb = 1;
      3'b001, 3'b101: nb = 2;
      3'b010:         nb = 4;
      default:        nb = 0;
    endcase
    if (nb == 0) e.err = 1'b1;
    else if (we && sz[2]) e.err = 1'b1;
    else if (a >= MEM_BYTES) e.err = 1'b1;
    else if ((a % nb) != 0) e.err = 1'b1;
    if (e.err) begin
      n_err++;
      return e;
    end
    if (we) begin
      n_st++;
      for (int i = 0; i < nb; i++) mem_m[a+i] = wd[8*i +: 8];
    end else begin
      n_ld++;
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[a+i];
      if (sz == 3'b000 && v[7])  v[31:8]  = '1;
      if (sz == 3'b001 && v[15]) v[31:16] = '1;
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic issue(input bit we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input bit use_k = 1'b0,
                       input logic [31:0] k = 32'd0);
    bit   acc;
    int   tries;
    exp_t e;
    acc = 1'b0;
    tries = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_addr = a; bus.req_wdata = wd;
    forever begin
      #1 acc = bus.req_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      tries++;
      if (tries > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: req_ready=%0b want 1", bus.req_ready);
        break;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    if (acc) begin
      e = model_req(we, sz, a, wd);
      if (use_k) e.rdata = k;
      e.acc   = cyc;
      e.timed = timed_mode;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      #3;
      t++;
    end
    check({tag, "_drain_left"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rr_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got rdata %h err %0b, want no response",
                   bus.rsp_rdata, bus.rsp_err);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
          check("rsp_is_store", {31'd0, bus.rsp_is_store}, {31'd0, e.st});
          if (e.timed) check("latency", cyc - e.acc + 1, RD_LAT);
        end
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout want finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [2:0]  sz;
    logic [31:0] a;
    bit          we;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_size = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check_perf("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int w = 0; w < int'(WIN_WORDS); w++) issue(1'b1, 3'b010, 4 * w, $urandom());
    drain("preload");

    issue(1'b1, 3'b010, 32'h10, 32'h8000_00FF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h8000_00FF);
    issue(1'b0, 3'b000, 32'h10, 32'h0, 1'b1, 32'hFFFF_FFFF);
    issue(1'b0, 3'b100, 32'h10, 32'h0, 1'b1, 32'h0000_00FF);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 32'hFFFF_8000);
    issue(1'b0, 3'b101, 32'h12, 32'h0, 1'b1, 32'h0000_8000);
    drain("extend");

    timed_mode = 1'b1;
    issue(1'b1, 3'b010, 32'h20, 32'h0);
    issue(1'b1, 3'b000, 32'h21, 32'hAB);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 32'h0000_AB00);
    drain("raw");
    timed_mode = 1'b0;

    issue(1'b0, 3'b010, 32'h22, 32'h0);
    issue(1'b1, 3'b001, 32'h33, 32'hFFFF_FFFF);
    issue(1'b0, 3'b010, 32'h1000, 32'h0);
    issue(1'b0, 3'b010, 32'h30, 32'h0);
    drain("errors");
    check_perf("errors");

    // Back-pressure: fill the pipe, hold a store at the port while stalled.
    rr_mode = 2;
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    issue(1'b0, 3'b010, 32'h44, 32'h0);
    issue(1'b0, 3'b010, 32'h48, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 3'b010;
      bus.req_addr = 32'h40; bus.req_wdata = 32'hDEAD_BEEF;
      #1;
      check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("stall_rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
    end
    bus.req_valid = 1'b0;
    rr_mode = 0;
    check_perf("stall");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("drain_rsp_valid", {31'd0, bus.rsp_valid}, (c < 3) ? 32'd1 : 32'd0);
    end
    drain("stall");
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    drain("stall_nowrite");

    rr_mode = 1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 12))
        0, 1:     sz = 3'b000;
        2, 3:     sz = 3'b001;
        4, 5, 6:  sz = 3'b010;
        7:        sz = 3'b100;
        8:        sz = 3'b101;
        9:        sz = 3'b011;
        10:       sz = 3'b110;
        11:       sz = 3'b111;
        default:  sz = 3'b010;
      endcase
      we = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 19) == 0) a = MEM_BYTES + $urandom_range(0, 1023);
      else a = $urandom_range(0, 4 * WIN_WORDS - 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      issue(we, sz, a, $urandom());
    end
    rr_mode = 0;
    drain("random");
    check_perf("random");

    // Reset with two loads in flight and a store at the port.
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 3'b010;
    bus.req_addr = 32'h44; bus.req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    exp_q.delete();
    n_ld = 0; n_st = 0; n_err = 0;
    check_idle("midreset");
    check_perf("midreset");
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    issue(1'b0, 3'b010, 32'h44, 32'h0);
    drain("reset");
    repeat (5) @(negedge clk);
    #3;
    check("final_queue", exp_q.size(), 32'd0);
    check_perf("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
